// File: rtl/ir_tx_pkg.sv
// rtl/ir_tx_pkg.sv - shared types, timing defaults and helpers for the IR transmit sequencer
// Purpose: FSM state enum, default timing constants (50 MHz clock), command word
//          widths and small helper functions used by ir_tx_sequencer and ir_key_debounce.
// Ports:   none (package)
package ir_tx_pkg;

  localparam int unsigned W_A = 35;
  localparam int unsigned W_B = 32;

  localparam int unsigned DEF_DEBOUNCE     = 1_000_000;
  localparam int unsigned DEF_T_LEAD_MARK  = 450_000;
  localparam int unsigned DEF_T_LEAD_SPACE = 225_000;
  localparam int unsigned DEF_T_MARK       = 31_000;
  localparam int unsigned DEF_T_SPACE0     = 27_000;
  localparam int unsigned DEF_T_SPACE1     = 83_000;
  localparam int unsigned DEF_T_GAP        = 1_000_000;
  localparam int unsigned DEF_CARRIER_HALF = 658;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_A_MARK,
    S_A_SPACE,
    S_GAP_MARK,
    S_GAP_SPACE,
    S_B_MARK,
    S_B_SPACE,
    S_STOP_MARK
  } state_t;

  function automatic int unsigned space_len(input logic bit_val,
                                            input int unsigned t_space0,
                                            input int unsigned t_space1);
    return bit_val ? t_space1 : t_space0;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Envelope is high in every mark state.
  function automatic logic is_mark(input state_t s);
    return s inside {S_LEAD_MARK, S_A_MARK, S_GAP_MARK, S_B_MARK, S_STOP_MARK};
  endfunction

endpackage

// File: rtl/ir_tx_sequencer_debounce.sv
// rtl/ir_tx_sequencer_debounce.sv - key synchronizer, debouncer and press pulse
// Purpose: module ir_key_debounce. Two-flop synchronizer on the raw key, a stable
//          counter that flips the debounced level after DEBOUNCE consecutive
//          samples differing from it, and a one-cycle req on each debounced 0->1.
// Ports:   clk, rst (async, active high), key_in (raw async key), req (1-cycle pulse)
module ir_key_debounce
  import ir_tx_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic req
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample equal to the current level restarts the run.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    req_d   = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        req_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      req_q   <= req_d;
    end
  end

  assign req = req_q;

endmodule

// File: rtl/ir_tx_sequencer.sv
// rtl/ir_tx_sequencer.sv - air-conditioner IR two-part frame transmitter
// Purpose: on a debounced key press, snapshot both command words and send
//          leader, 35 A bits (LSB first), connector, 32 B bits, stop mark,
//          gating the carrier onto IR_out. One press during a frame is queued.
// Ports:   clk, rst (async, active high), key_1 (raw key), IR_in_data35,
//          IR_in_data32 (command words), IR_out (modulated drive, registered),
//          led_out (frame in progress, registered)
module ir_tx_sequencer
  import ir_tx_pkg::*;
#(
  parameter int unsigned DEBOUNCE     = DEF_DEBOUNCE,
  parameter int unsigned T_LEAD_MARK  = DEF_T_LEAD_MARK,
  parameter int unsigned T_LEAD_SPACE = DEF_T_LEAD_SPACE,
  parameter int unsigned T_MARK       = DEF_T_MARK,
  parameter int unsigned T_SPACE0     = DEF_T_SPACE0,
  parameter int unsigned T_SPACE1     = DEF_T_SPACE1,
  parameter int unsigned T_GAP        = DEF_T_GAP,
  parameter int unsigned CARRIER_HALF = DEF_CARRIER_HALF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_1,
  input  logic [W_A-1:0] IR_in_data35,
  input  logic [W_B-1:0] IR_in_data32,
  output logic           IR_out,
  output logic           led_out
);

  localparam int unsigned MAX_DUR = max_u(max_u(max_u(T_LEAD_MARK, T_LEAD_SPACE),
                                                max_u(T_MARK, T_SPACE0)),
                                          max_u(T_SPACE1, T_GAP));
  localparam int unsigned DW = $clog2(MAX_DUR + 1);
  localparam int unsigned CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_HALF - 1);

  logic req;

  ir_key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_1),
    .req    (req)
  );

  state_t         state_q, state_d;
  logic [DW-1:0]  dur_q, dur_d;
  logic [5:0]     bit_q, bit_d;
  logic [W_A-1:0] data_a_q, data_a_d;
  logic [W_B-1:0] data_b_q, data_b_d;
  logic           pend_q, pend_d;
  logic [CW-1:0]  car_cnt_q, car_cnt_d;
  logic           car_ph_q, car_ph_d;
  logic           ir_q, ir_d;
  logic           led_q, led_d;

  // The duration counter holds remaining cycles minus one; zero is terminal.
  function automatic logic [DW-1:0] load(input int unsigned n);
    return DW'(n - 1);
  endfunction

  always_comb begin
    state_d  = state_q;
    dur_d    = dur_q;
    bit_d    = bit_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    pend_d   = pend_q;

    if (req && state_q != S_IDLE) pend_d = 1'b1;

    if (state_q == S_IDLE) begin
      if (req || pend_q) begin
        state_d  = S_LEAD_MARK;
        dur_d    = load(T_LEAD_MARK);
        data_a_d = IR_in_data35;
        data_b_d = IR_in_data32;
        pend_d   = 1'b0;
      end
    end else if (dur_q != '0) begin
      dur_d = dur_q - DW'(1);
    end else begin
      case (state_q)
        S_LEAD_MARK: begin
          state_d = S_LEAD_SPACE;
          dur_d   = load(T_LEAD_SPACE);
        end
        S_LEAD_SPACE: begin
          state_d = S_A_MARK;
          dur_d   = load(T_MARK);
          bit_d   = '0;
        end
        S_A_MARK: begin
          state_d = S_A_SPACE;
          dur_d   = load(space_len(data_a_q[bit_q], T_SPACE0, T_SPACE1));
        end
        S_A_SPACE: begin
          dur_d = load(T_MARK);
          if (bit_q == 6'(W_A - 1)) begin
            state_d = S_GAP_MARK;
          end else begin
            state_d = S_A_MARK;
            bit_d   = bit_q + 6'd1;
          end
        end
        S_GAP_MARK: begin
          state_d = S_GAP_SPACE;
          dur_d   = load(T_GAP);
        end
        S_GAP_SPACE: begin
          state_d = S_B_MARK;
          dur_d   = load(T_MARK);
          bit_d   = '0;
        end
        S_B_MARK: begin
          state_d = S_B_SPACE;
          dur_d   = load(space_len(data_b_q[bit_q[4:0]], T_SPACE0, T_SPACE1));
        end
        S_B_SPACE: begin
          dur_d = load(T_MARK);
          if (bit_q == 6'(W_B - 1)) begin
            state_d = S_STOP_MARK;
          end else begin
            state_d = S_B_MARK;
            bit_d   = bit_q + 6'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          dur_d   = '0;
        end
      endcase
    end

    // Carrier restarts high on every mark entry so each burst starts identically.
    car_cnt_d = car_cnt_q;
    car_ph_d  = car_ph_q;
    if (state_d != state_q && is_mark(state_d)) begin
      car_cnt_d = '0;
      car_ph_d  = 1'b1;
    end else if (car_cnt_q == CAR_LAST) begin
      car_cnt_d = '0;
      car_ph_d  = ~car_ph_q;
    end else begin
      car_cnt_d = car_cnt_q + CW'(1);
    end

    ir_d  = is_mark(state_d) & car_ph_d;
    led_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dur_q     <= '0;
      bit_q     <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      pend_q    <= 1'b0;
      car_cnt_q <= '0;
      car_ph_q  <= 1'b0;
      ir_q      <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      bit_q     <= bit_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      pend_q    <= pend_d;
      car_cnt_q <= car_cnt_d;
      car_ph_q  <= car_ph_d;
      ir_q      <= ir_d;
      led_q     <= led_d;
    end
  end

  assign IR_out  = ir_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_ir_tx_sequencer.sv
// tb/tb_ir_tx_sequencer.sv - self-checking bench for ir_tx_sequencer
module tb_ir_tx_sequencer;

  localparam int DEB = 3;
  localparam int TLM = 8;
  localparam int TLS = 4;
  localparam int TM  = 2;
  localparam int TS0 = 2;
  localparam int TS1 = 5;
  localparam int TG  = 10;
  localparam int CH  = 1;
  localparam int MAXC = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_1 = 1'b0;
  logic [34:0] d35 = '0;
  logic [31:0] d32 = '0;
  logic        IR_out, led_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit obs_ir [MAXC];
  bit obs_led[MAXC];

  ir_tx_sequencer #(
    .DEBOUNCE(DEB), .T_LEAD_MARK(TLM), .T_LEAD_SPACE(TLS), .T_MARK(TM),
    .T_SPACE0(TS0), .T_SPACE1(TS1), .T_GAP(TG), .CARRIER_HALF(CH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_1        (key_1),
    .IR_in_data35 (d35),
    .IR_in_data32 (d32),
    .IR_out       (IR_out),
    .led_out      (led_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural model: key delayed by the synchronizer, run-length debounce,
  // and each frame expanded into a per-cycle expected IR waveform.
  bit m_kd1, m_kd2, m_level, m_req, m_pend, m_active;
  int m_run, m_pos;
  bit m_frame[$];
  bit exp_ir, exp_led;

  function automatic void push_seg(bit mark, int n);
    for (int i = 0; i < n; i++) m_frame.push_back(mark ? (((i / CH) % 2) == 0) : 1'b0);
  endfunction

  function automatic void build_frame(logic [34:0] a, logic [31:0] b);
    m_frame.delete();
    push_seg(1, TLM);
    push_seg(0, TLS);
    for (int i = 0; i < 35; i++) begin
      push_seg(1, TM);
      push_seg(0, a[i] ? TS1 : TS0);
    end
    push_seg(1, TM);
    push_seg(0, TG);
    for (int i = 0; i < 32; i++) begin
      push_seg(1, TM);
      push_seg(0, b[i] ? TS1 : TS0);
    end
    push_seg(1, TM);
  endfunction

  initial forever begin
    bit busy, smp;
    @(posedge clk);
    if (rst) begin
      m_kd1 = 0; m_kd2 = 0; m_level = 0; m_req = 0; m_pend = 0;
      m_active = 0; m_run = 0; m_pos = 0;
      exp_ir = 0; exp_led = 0;
    end else begin
      busy = m_active;
      if (m_req && busy) m_pend = 1;
      if (m_active) begin
        m_pos++;
        if (m_pos == m_frame.size()) m_active = 0;
      end
      if (!busy && (m_req || m_pend)) begin
        build_frame(d35, d32);
        m_pos = 0;
        m_active = 1;
        m_pend = 0;
      end
      exp_led = m_active;
      exp_ir  = m_active ? m_frame[m_pos] : 1'b0;
      smp = m_kd2;
      m_kd2 = m_kd1;
      m_kd1 = key_1;
      m_req = 0;
      if (smp != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = smp;
          m_run = 0;
          m_req = smp;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cyc < MAXC) begin
      obs_ir[cyc]  = IR_out;
      obs_led[cyc] = led_out;
    end
    if (!rst) begin
      checks++;
      if (IR_out !== exp_ir || led_out !== exp_led) begin
        errors++;
        $display("FAIL model cycle %0d: IR_out/led_out got %b/%b expected %b/%b",
                 cyc, IR_out, led_out, exp_ir, exp_led);
      end
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hold);
    key_1 = 1'b1;
    tick(hold);
    key_1 = 1'b0;
    tick(8);
  endtask

  // Decode recorded outputs: frames, bursts, first frame cycle, first idle gap
  // and data bits (zero run after a data mark = 1 low carrier cycle + space).
  task automatic analyze(input int from, input int to, output int led_cnt,
                         output int bursts, output int nframes, output int first_led,
                         output int gap, output logic [66:0] bits);
    int  zr, idle_run, nbits;
    bit  pl;
    led_cnt = 0; bursts = 0; nframes = 0; first_led = -1; gap = -1;
    bits = '0; nbits = 0; zr = 99; idle_run = 0; pl = 0;
    for (int c = from; c < to; c++) begin
      if (obs_led[c]) begin
        led_cnt++;
        if (!pl) begin
          nframes++;
          if (first_led < 0) first_led = c;
          if (nframes == 2) gap = idle_run;
        end
        if (obs_ir[c]) begin
          if (zr >= 2) bursts++;
          if (nbits < 67 && (zr == TS0 + 1 || zr == TS1 + 1)) begin
            bits[nbits] = (zr == TS1 + 1);
            nbits++;
          end
          zr = 0;
        end else begin
          zr++;
        end
      end else begin
        if (pl) idle_run = 0;
        idle_run++;
        zr = 99;
      end
      pl = obs_led[c];
    end
  endtask

  initial begin
    int p, lc, bu, nf, fl, gp;
    logic [66:0] bits;

    tick(4);
    check("reset_ir_out", IR_out, 0);
    check("reset_led_out", led_out, 0);
    rst = 1'b0;
    tick(5);

    // all-zero words
    p = cyc;
    press(8);
    tick(320);
    analyze(p, cyc, lc, bu, nf, fl, gp, bits);
    check("zero_led_cycles", lc, 294);
    check("zero_bursts", bu, 70);
    check("press_latency", fl, p + 6);
    check("zero_bits", bits, 0);

    // all-ones words
    d35 = '1; d32 = '1;
    p = cyc;
    press(8);
    tick(520);
    analyze(p, cyc, lc, bu, nf, fl, gp, bits);
    check("ones_led_cycles", lc, 495);
    check("ones_bits_a", bits[34:0], 35'h7FFFFFFFF);
    check("ones_bits_b", bits[66:35], 32'hFFFFFFFF);

    // pattern, with inputs scrambled mid-frame
    d35 = 35'h7C1F07C1F; d32 = 32'hF83E0F83;
    p = cyc;
    press(8);
    d35 = {3'($urandom_range(0, 7)), $urandom()};
    d32 = $urandom();
    tick(520);
    analyze(p, cyc, lc, bu, nf, fl, gp, bits);
    check("pattern_a", bits[34:0], 35'h7C1F07C1F);
    check("pattern_b", bits[66:35], 32'hF83E0F83);
    check("pattern_frames", nf, 1);

    // 2-cycle glitch
    p = cyc;
    key_1 = 1'b1;
    tick(2);
    key_1 = 1'b0;
    tick(30);
    analyze(p, cyc, lc, bu, nf, fl, gp, bits);
    check("glitch_led_cycles", lc, 0);

    // start press plus two presses during the frame
    d35 = {3'($urandom_range(0, 7)), $urandom()};
    d32 = $urandom();
    p = cyc;
    press(8);
    press(8);
    press(8);
    tick(1100);
    analyze(p, cyc, lc, bu, nf, fl, gp, bits);
    check("pending_frames", nf, 2);
    check("pending_idle_gap", gp, 1);

    // reset during B bits
    d35 = '0; d32 = $urandom();
    press(8);
    tick(190);
    check("busy_before_reset", led_out, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_ir", IR_out, 0);
    check("async_reset_led", led_out, 0);
    tick(3);
    rst = 1'b0;
    p = cyc;
    tick(40);
    analyze(p, cyc, lc, bu, nf, fl, gp, bits);
    check("post_reset_idle", lc, 0);
    d32 = $urandom();
    press(8);
    tick(520);

    // random presses, glitches and data
    for (int i = 0; i < 6; i++) begin
      d35 = {3'($urandom_range(0, 7)), $urandom()};
      d32 = $urandom();
      key_1 = 1'b1;
      tick($urandom_range(1, 10));
      key_1 = 1'b0;
      tick($urandom_range(4, 40));
      tick($urandom_range(0, 600));
    end
    tick(1200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_tx_sequencer.md
# ir_tx_sequencer

Controller for the air-conditioner infrared transmit path. On a debounced press of `key_1` it snapshots the 35-bit and 32-bit command words, then walks the complete two-part frame: leader, 35 data bits, connector gap, 32 data bits, stop mark. It gates a 38 kHz carrier onto `IR_out` and reports activity on `led_out`. It sits between the key input and the IR LED driver, and replaces hand-sequenced frame timing.

## Interface
- `DEBOUNCE`, 1_000_000: cycles `key_1` must be stable high (20 ms @ 50 MHz)
- `T_LEAD_MARK`, 450_000: leader mark cycles (9 ms)
- `T_LEAD_SPACE`, 225_000: leader space cycles (4.5 ms)
- `T_MARK`, 31_000: data, connector and stop mark cycles (620 µs)
- `T_SPACE0`, 27_000: space cycles for a 0 bit (540 µs)
- `T_SPACE1`, 83_000: space cycles for a 1 bit (1.66 ms)
- `T_GAP`, 1_000_000: connector space cycles (20 ms)
- `CARRIER_HALF`, 658: carrier half-period cycles (≈38 kHz)
- `clk` in 1: system clock, 50 MHz
- `rst` in 1: asynchronous, active-high reset
- `key_1` in 1: raw key, asynchronous, pressed = 1
- `IR_in_data35` in 35: first command word, sampled at frame start
- `IR_in_data32` in 32: second command word, sampled at frame start
- `IR_out` out 1: modulated IR drive, registered
- `led_out` out 1: high while a frame is in progress, registered

## Operation
- Key path:
  - `key_1` passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level flips only after `DEBOUNCE` consecutive equal samples.
  - A debounced 0→1 edge produces a one-cycle `req`.
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, A_MARK, A_SPACE, GAP_MARK, GAP_SPACE, B_MARK, B_SPACE, STOP_MARK.
- IDLE:
  - On `req` or `pending`, latch both data words, clear `pending` and enter LEAD_MARK.
- Transitions:
  - LEAD_MARK (`T_LEAD_MARK`) → LEAD_SPACE (`T_LEAD_SPACE`) → A_MARK.
  - A_MARK (`T_MARK`) → A_SPACE, which lasts `T_SPACE1` if the current bit is 1, else `T_SPACE0`.
  - After 35 A bits → GAP_MARK (`T_MARK`) → GAP_SPACE (`T_GAP`) → B_MARK.
  - B bits follow the A rule, 32 of them → STOP_MARK (`T_MARK`) → IDLE.
- Bit order is LSB first: bit 0 of each latched word goes out first.
- Bit index is 6 bits wide and resets to 0 on entering A_MARK from LEAD_SPACE and on entering B_MARK from GAP_SPACE.
- Envelope is 1 in *_MARK states and 0 otherwise. `IR_out` = envelope AND carrier.
- Carrier:
  - A free counter that restarts at phase 0 (high) on every mark entry.
  - High for `CARRIER_HALF` cycles, then low for `CARRIER_HALF` cycles.
- `led_out` = (state ≠ IDLE).
- Press while busy:
  - Sets `pending`; further presses while `pending` is set are dropped.
  - On reaching IDLE with `pending` set, the next frame starts on the following cycle with freshly sampled data.
- Reset, any time including mid-frame:
  - State IDLE; `IR_out`=0, `led_out`=0.
  - `pending`=0, all counters 0, debounced level 0.
  - No partial frame resumes.
- Data-word changes mid-frame have no effect until the next frame start.

## Timing
- Every state lasts exactly its parameter count in cycles. The duration counter loads on entry and the state exits when it hits its terminal count.
- Latency:
  - `req` high in cycle N (state IDLE) gives `IR_out`=1 and `led_out`=1 from the edge ending cycle N.
  - `key_1` rising to `req` takes 2 (sync) + `DEBOUNCE` + 1 cycles.
- Frame length L = `T_LEAD_MARK` + `T_LEAD_SPACE` + 68·`T_MARK` + Σspaces + `T_GAP` + `T_MARK`.
- `led_out` is high for exactly L cycles per frame.
- Back-to-back frames from `pending` are separated by exactly 1 IDLE cycle with `led_out`=0.
- Counter widths: ceil(log2(max duration parameter + 1)); the carrier counter uses ceil(log2(`CARRIER_HALF`)).

## Structure
- Shared package `ir_tx_pkg` holds:
  - the state enum
  - default timing constants
  - the word widths 35 and 32
  - a function returning the space length for a given bit value
- One sub-module, `ir_key_debounce`: synchronizer, stable counter and edge pulse, parameter `DEBOUNCE`.
- The FSM, carrier and datapath stay in the top.

## Test plan
All cases use small parameters: `DEBOUNCE`=3, `T_LEAD_MARK`=8, `T_LEAD_SPACE`=4, `T_MARK`=2, `T_SPACE0`=2, `T_SPACE1`=5, `T_GAP`=10, `CARRIER_HALF`=1.
- All-zero words, single press:
  - `led_out` high for exactly 294 cycles.
  - 70 mark bursts: leader, 35 A, gap, 32 B, stop.
  - `IR_out` toggles 1,0 within each mark.
- All-ones words: `led_out` high for 495 cycles; each data space is 5 cycles.
- Data `IR_in_data35`=35'h7C1F07C1F, `IR_in_data32`=32'hF83E0F83 (from bit 0): decoded space lengths give back both words exactly, LSB first.
- Key glitches:
  - A 2-cycle glitch produces no frame.
  - A clean press (≥6 cycles high) starts the frame 6 cycles after `key_1` rises.
- Two presses during a frame, then a third press: exactly one extra frame follows after 1 idle cycle; the third press is dropped.
- `rst` asserted mid-B-bits:
  - `IR_out`=0 and `led_out`=0 immediately, without waiting for a clock edge.
  - After release, idle stays with no output until a new press.
